// File: rtl/fp32_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : fp32_adder_bist
// Purpose  : Built-in self-test initiator/checker for the fp32 adder streaming
//            interface. Golden vectors {A, B, Res, Flags} are read from a
//            synchronous ROM and issued to the adder at up to one per clock.
//            The expected {Res, Flags} values are held in an in-order FIFO and
//            checked against each adder result. The module reports pass/fail,
//            error and transaction counters, and a drain timeout.
// Ports    : clk_i, rst_i (async, active high), start_i
//            rom_addr_o / rom_data_i        - vector ROM (1-cycle read latency)
//            dut_valid_o, dut_a_o, dut_b_o  - adder stimulus
//            dut_result_i, dut_done_i, dut_{overflow,underflow,invalid}_i
//            busy_o, done_o, pass_o, err_count_o, tx_count_o,
//            first_err_idx_o, timeout_o     - status
// Option   : FP32_BIST_CAPTURE_EN adds first_err_got_o, first_err_exp_o and
//            first_err_flags_o {inv, un, ov, mismatch_was_flag}.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_adder_bist #(
    parameter int NUM_VECTORS = 10000,
    parameter int ADDR_W      = 14,
    parameter int FIFO_DEPTH  = 16,
    parameter int ULP_TOL     = 3,
    parameter int MAX_LATENCY = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [103:0]      rom_data_i,
    output logic              dut_valid_o,
    output logic [31:0]       dut_a_o,
    output logic [31:0]       dut_b_o,
    input  logic [31:0]       dut_result_i,
    input  logic              dut_done_i,
    input  logic              dut_overflow_i,
    input  logic              dut_underflow_i,
    input  logic              dut_invalid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_count_o,
    output logic [15:0]       tx_count_o,
    output logic [ADDR_W-1:0] first_err_idx_o,
`ifdef FP32_BIST_CAPTURE_EN
    output logic [31:0]       first_err_got_o,
    output logic [31:0]       first_err_exp_o,
    output logic [3:0]        first_err_flags_o,
`endif
    output logic              timeout_o
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_SUM_W  = c_CNT_W + 1;
    localparam int c_IDLE_W = $clog2(MAX_LATENCY + 1);
    localparam int c_ENT_W  = 35;   // {res[31:0], inv, ov, un}
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LIM  = c_IDLE_W'(MAX_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_rd_pend;     // ROM word arriving this cycle
    logic [c_ENT_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_fifo_cnt;
    logic [c_IDLE_W-1:0]  r_idle;
    logic [ADDR_W-1:0]    r_chk_idx;
    logic                 r_have_err;

    // Inexact and reserved flag bits are never checked.
    logic w_unused_flags;
    assign w_unused_flags = ^{rom_data_i[7:5], rom_data_i[3], rom_data_i[0]};

    logic               w_start;
    logic               w_checking;
    logic               w_room;
    logic               w_fetch;
    logic               w_push;
    logic               w_fifo_empty;
    logic               w_done_chk;
    logic               w_pop;
    logic               w_spurious;
    logic [c_ENT_W-1:0] w_push_ent;
    logic [c_ENT_W-1:0] w_head;
    logic [31:0]        w_gold;
    logic               w_gold_inv;
    logic               w_gold_ov;
    logic               w_gold_un;

    assign w_start      = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_checking   = (r_state == S_RUN) || (r_state == S_DRAIN);
    // The word in flight from the ROM already owns a FIFO slot.
    assign w_room       = (c_SUM_W'(r_fifo_cnt) + c_SUM_W'(r_rd_pend)) < c_SUM_W'(FIFO_DEPTH);
    assign w_fetch      = (r_state == S_RUN) && w_room;
    assign w_push       = r_rd_pend;
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_done_chk   = dut_done_i && w_checking;
    assign w_pop        = w_done_chk && (!w_fifo_empty || w_push);
    assign w_spurious   = w_done_chk && w_fifo_empty && !w_push;
    assign w_push_ent   = {rom_data_i[39:8], rom_data_i[4], rom_data_i[2], rom_data_i[1]};
    // Empty FIFO with a same-cycle push: the incoming entry is the head.
    assign w_head       = w_fifo_empty ? w_push_ent : r_fifo_mem[r_rd_ptr];
    assign w_gold       = w_head[34:3];
    assign w_gold_inv   = w_head[2];
    assign w_gold_ov    = w_head[1];
    assign w_gold_un    = w_head[0];

    // ---------------------------------------------------------------- compare
    logic               w_res_zero;
    logic               w_ftz;
    logic               w_gold_nan;
    logic               w_res_nan;
    logic signed [32:0] w_diff;
    logic [32:0]        w_abs;
    logic               w_res_ok;
    logic               w_flg_ok;
    logic               w_mismatch;

    assign w_res_zero = (dut_result_i[30:0] == 31'd0);
    assign w_ftz      = dut_underflow_i && w_res_zero && (w_gold[30:23] == 8'd0);
    assign w_gold_nan = (w_gold[30:23] == 8'hFF) && (w_gold[22:0] != 23'd0);
    assign w_res_nan  = (dut_result_i[30:23] == 8'hFF) && (dut_result_i[22:0] != 23'd0);
    assign w_diff     = $signed({dut_result_i[31], dut_result_i}) - $signed({w_gold[31], w_gold});
    assign w_abs      = w_diff[32] ? (~w_diff + 33'd1) : w_diff;

    always_comb begin
        w_res_ok = 1'b0;
        if (w_ftz) begin
            w_res_ok = 1'b1;
        end else if (w_gold_nan) begin
            w_res_ok = w_res_nan;
        end else begin
            w_res_ok = (dut_result_i == w_gold) || (w_abs <= 33'(ULP_TOL));
        end
    end

    // A flushed-to-zero result may raise underflow where the golden did not.
    assign w_flg_ok   = (dut_overflow_i == w_gold_ov) &&
                        (dut_invalid_i  == w_gold_inv) &&
                        ((dut_underflow_i == w_gold_un) || (dut_underflow_i && w_res_zero));
    assign w_mismatch = w_pop && !(w_res_ok && w_flg_ok);

    logic        w_timeout;
    logic        w_drain_end;
    logic [15:0] w_err_nxt;

    assign w_drain_end = w_fifo_empty && !r_rd_pend;
    assign w_timeout   = (r_state == S_DRAIN) && !dut_done_i && (r_idle == c_IDLE_LIM);
    assign w_err_nxt   = ((w_mismatch || w_spurious) && (err_count_o != 16'hFFFF)) ?
                         err_count_o + 16'd1 : err_count_o;

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_fetch && (rom_addr_o == c_LAST_ADDR)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_timeout || w_drain_end) w_state_nxt = S_DONE;
            S_DONE:  if (w_start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy_o = w_checking;

    // ------------------------------------------------------- FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_ent;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rom_addr_o      <= '0;
            dut_valid_o     <= 1'b0;
            dut_a_o         <= '0;
            dut_b_o         <= '0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            timeout_o       <= 1'b0;
            err_count_o     <= '0;
            tx_count_o      <= '0;
            first_err_idx_o <= '0;
            r_rd_pend       <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fifo_cnt      <= '0;
            r_idle          <= '0;
            r_chk_idx       <= '0;
            r_have_err      <= 1'b0;
`ifdef FP32_BIST_CAPTURE_EN
            first_err_got_o   <= '0;
            first_err_exp_o   <= '0;
            first_err_flags_o <= '0;
`endif
        end else if (w_start) begin
            rom_addr_o      <= '0;
            dut_valid_o     <= 1'b0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            timeout_o       <= 1'b0;
            err_count_o     <= '0;
            tx_count_o      <= '0;
            first_err_idx_o <= '0;
            r_rd_pend       <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fifo_cnt      <= '0;
            r_idle          <= '0;
            r_chk_idx       <= '0;
            r_have_err      <= 1'b0;
`ifdef FP32_BIST_CAPTURE_EN
            first_err_got_o   <= '0;
            first_err_exp_o   <= '0;
            first_err_flags_o <= '0;
`endif
        end else begin
            // Fetch: the address is held on the final vector.
            r_rd_pend <= w_fetch;
            if (w_fetch && (rom_addr_o != c_LAST_ADDR)) begin
                rom_addr_o <= rom_addr_o + 1'b1;
            end

            // Issue: the word returned by the ROM goes straight to the adder.
            dut_valid_o <= r_rd_pend;
            if (r_rd_pend) begin
                dut_a_o <= rom_data_i[103:72];
                dut_b_o <= rom_data_i[71:40];
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end

            err_count_o <= w_err_nxt;
            if (w_pop) begin
                r_chk_idx <= r_chk_idx + 1'b1;
                if (tx_count_o != 16'hFFFF) begin
                    tx_count_o <= tx_count_o + 16'd1;
                end
            end
            if (w_mismatch && !r_have_err) begin
                r_have_err      <= 1'b1;
                first_err_idx_o <= r_chk_idx;
`ifdef FP32_BIST_CAPTURE_EN
                first_err_got_o   <= dut_result_i;
                first_err_exp_o   <= w_gold;
                first_err_flags_o <= {dut_invalid_i, dut_underflow_i, dut_overflow_i, !w_flg_ok};
`endif
            end

            if ((r_state != S_DRAIN) || dut_done_i) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
                done_o    <= 1'b1;
                timeout_o <= w_timeout;
                pass_o    <= (w_err_nxt == 16'd0) && !w_timeout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_adder_bist
// Purpose  : Self-checking bench for fp32_adder_bist. A behavioural ROM and a
//            latency-programmable adder model surround the checker. Every
//            start loads a scoreboard with the expected operand sequence; each
//            adder issue is popped and compared. Final status is compared
//            against values derived from the directed scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_adder_bist;

    localparam int c_N  = 100;
    localparam int c_AW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [c_AW-1:0] rom_addr;
    logic [103:0]    rom_q;
    logic            dut_valid;
    logic [31:0]     dut_a, dut_b;
    logic [31:0]     res_drv;
    logic            done_drv, ov_drv, un_drv, inv_drv;
    logic            busy, done, pass, timeout;
    logic [15:0]     err_count, tx_count;
    logic [c_AW-1:0] first_idx;
`ifdef FP32_BIST_CAPTURE_EN
    logic [31:0]     cap_got, cap_exp;
    logic [3:0]      cap_flags;
`endif

    fp32_adder_bist #(
        .NUM_VECTORS (c_N),
        .ADDR_W      (c_AW),
        .FIFO_DEPTH  (16),
        .ULP_TOL     (3),
        .MAX_LATENCY (64)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_q),
        .dut_valid_o     (dut_valid),
        .dut_a_o         (dut_a),
        .dut_b_o         (dut_b),
        .dut_result_i    (res_drv),
        .dut_done_i      (done_drv),
        .dut_overflow_i  (ov_drv),
        .dut_underflow_i (un_drv),
        .dut_invalid_i   (inv_drv),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_count_o     (err_count),
        .tx_count_o      (tx_count),
        .first_err_idx_o (first_idx),
`ifdef FP32_BIST_CAPTURE_EN
        .first_err_got_o   (cap_got),
        .first_err_exp_o   (cap_exp),
        .first_err_flags_o (cap_flags),
`endif
        .timeout_o       (timeout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ ROM
    logic [103:0] rom [0:127];
    always @(posedge clk) rom_q <= rom[rom_addr];

    // ---------------------------------------------------------- bookkeeping
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // --------------------------------------------------------- adder model
    int          lat = 3;
    int          drop_from = 1000;
    bit          ovr_en  [128];
    logic [31:0] ovr_res [128];
    logic [2:0]  ovr_fl  [128];      // {inv, un, ov}
    bit          spur = 1'b0;

    int          cyc = 0;
    int          issue_idx, n_valid, out_cnt, max_out;
    int          first_valid_cyc, last_valid_cyc, last_done_cyc;
    int          mq_due[$];
    int          mq_idx[$];
    logic [63:0] sb[$];

    always @(posedge clk) cyc++;

    initial begin
        done_drv = 1'b0; res_drv = '0; ov_drv = 1'b0; un_drv = 1'b0; inv_drv = 1'b0;
    end

    always @(negedge clk) begin
        int idx;
        logic [63:0] exp_ab;
        if (rst) begin
            mq_due.delete();
            mq_idx.delete();
            done_drv = 1'b0;
        end else begin
            if (start) begin
                mq_due.delete();
                mq_idx.delete();
                sb.delete();
                for (int i = 0; i < c_N; i++) sb.push_back({rom[i][103:72], rom[i][71:40]});
                issue_idx = 0; n_valid = 0; out_cnt = 0; max_out = 0;
            end
            if (dut_valid) begin
                if (n_valid == 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
                n_valid++;
                if (sb.size() == 0) begin
                    chk("sb_extra_issue", 1, 0);
                end else begin
                    exp_ab = sb.pop_front();
                    chk("sb_operands", {dut_a, dut_b}, exp_ab);
                end
                if (issue_idx < drop_from) begin
                    mq_due.push_back(cyc + lat);
                    mq_idx.push_back(issue_idx);
                end
                issue_idx++;
                out_cnt++;
                if (out_cnt > max_out) max_out = out_cnt;
            end
            done_drv = 1'b0;
            if ((mq_due.size() > 0) && (mq_due[0] <= cyc)) begin
                void'(mq_due.pop_front());
                idx = mq_idx.pop_front();
                done_drv = 1'b1;
                out_cnt--;
                last_done_cyc = cyc;
                if (ovr_en[idx]) begin
                    res_drv = ovr_res[idx];
                    {inv_drv, un_drv, ov_drv} = ovr_fl[idx];
                end else begin
                    res_drv = rom[idx][39:8];
                    {inv_drv, un_drv, ov_drv} = {rom[idx][4], rom[idx][1], rom[idx][2]};
                end
            end
            if (spur) done_drv = 1'b1;
        end
    end

    // --------------------------------------------------------- run helpers
    int done_cyc;

    task automatic run_test(input int limit);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) break;
        end
        done_cyc = cyc;
        chk("done_seen", done, 1'b1);
    endtask

    task automatic clear_ovr();
        for (int i = 0; i < 128; i++) begin
            ovr_en[i] = 1'b0; ovr_res[i] = '0; ovr_fl[i] = '0;
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_ovr();
        for (int i = 0; i < 128; i++) begin
            rom[i] = {32'h4000_0000 + 32'(i), 32'hC000_0000 ^ (32'(i) * 32'h1357),
                      32'h3F00_0000 + 32'(i) * 32'd16, ((i % 3) == 0) ? 8'h01 : 8'h00};
        end
        rom[5][39:0]  = {32'h3F80_0000, 8'h00};
        rom[10][39:0] = {32'h0000_0001, 8'h00};
        rom[20][39:0] = {32'h7FC0_0000, 8'h10};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, pass, err_count, tx_count, first_idx, timeout,
                              dut_valid, dut_a, dut_b, rom_addr}, '0);
        #1 rst = 1'b0;

        // Spurious completions before any start are ignored
        @(posedge clk); #1 spur = 1'b1;
        repeat (3) @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        chk("idle_spur_status", {busy, done, err_count, tx_count, dut_valid}, '0);

        // Ideal adder, latency 3
        run_test(2000);
        chk("ideal_pass", {pass, timeout, err_count, tx_count}, {1'b1, 1'b0, 16'd0, 16'd100});
        chk("ideal_busy", busy, 1'b0);
        chk("ideal_issues", n_valid, c_N);
        chk("ideal_back_to_back", last_valid_cyc - first_valid_cyc, c_N - 1);
        chk("ideal_sb_empty", sb.size(), 0);

        // Within ULP tolerance
        ovr_en[5] = 1'b1; ovr_res[5] = 32'h3F80_0003;
        run_test(2000);
        chk("ulp3_pass", {pass, err_count, tx_count}, {1'b1, 16'd0, 16'd100});

        // One ULP beyond tolerance
        ovr_res[5] = 32'h3F80_0004;
        run_test(2000);
        chk("ulp4_fail", {pass, err_count, tx_count}, {1'b0, 16'd1, 16'd100});
        chk("ulp4_first_idx", first_idx, 7'd5);

        // FTZ of a denormal and NaN-vs-NaN both match
        clear_ovr();
        ovr_en[10] = 1'b1; ovr_res[10] = 32'h8000_0000; ovr_fl[10] = 3'b010;
        ovr_en[20] = 1'b1; ovr_res[20] = 32'h7F80_0001; ovr_fl[20] = 3'b100;
        run_test(2000);
        chk("ftz_nan_pass", {pass, err_count}, {1'b1, 16'd0});

        // Overflow flag raised where golden has none
        ovr_en[30] = 1'b1; ovr_res[30] = rom[30][39:8]; ovr_fl[30] = 3'b001;
        run_test(2000);
        chk("flag_fail", {pass, err_count}, {1'b0, 16'd1});
        chk("flag_first_idx", first_idx, 7'd30);

        // Long latency: outstanding work is bounded by the FIFO depth
        clear_ovr();
        lat = 40;
        run_test(4000);
        chk("lat40_pass", {pass, err_count, tx_count}, {1'b1, 16'd0, 16'd100});
        chk("lat40_max_outstanding", max_out, 16);

        // Last two results never return: drain timeout
        lat = 3;
        drop_from = c_N - 2;
        run_test(2000);
        chk("timeout_status", {done, timeout, pass, err_count, tx_count},
            {1'b1, 1'b1, 1'b0, 16'd0, 16'd98});
        // 64 idle cycles follow the last completion; DONE is visible the cycle after.
        chk("timeout_delay", done_cyc - last_done_cyc, 65);

        // Reset in the middle of a run, then a clean rerun
        drop_from = 1000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_valid >= 37) break;
        end
        chk("midrun_reached_37", n_valid >= 37, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", {busy, done, pass, err_count, tx_count, first_idx, timeout,
                                     dut_valid, dut_a, dut_b, rom_addr}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_test(2000);
        chk("rerun_pass", {pass, timeout, err_count, tx_count}, {1'b1, 1'b0, 16'd0, 16'd100});
        chk("rerun_issues", n_valid, c_N);
        chk("rerun_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_adder_bist.md
Name: fp32_adder_bist

Overview:
- Synthesizable built-in self-test initiator/checker for the fp32Adder streaming interface (valid_i/A/B in; result_o/done_o/flags out).
- Reads 104-bit golden vectors {A[103:72], B[71:40], Res[39:8], Flags[7:0]} from a synchronous ROM and streams them into the adder at up to one per cycle.
- Tracks expected results in an in-order FIFO, checks each adder output against its golden value, and reports pass/fail and counters for on-silicon or FPGA regression.

Parameters:
- NUM_VECTORS, 10000, number of vectors run per test (ROM addresses 0..NUM_VECTORS-1).
- ADDR_W, 14, ROM address width; must satisfy 2**ADDR_W >= NUM_VECTORS.
- FIFO_DEPTH, 16, expected-result FIFO entries (power of 2, >= 4).
- ULP_TOL, 3, allowed |result - golden| as a signed 32-bit integer difference.
- MAX_LATENCY, 64, drain-phase idle-cycle limit before timeout.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a run.
- rom_addr_o  out  ADDR_W  vector ROM address.
- rom_data_i  in  104  ROM data, valid 1 cycle after the address is presented.
- dut_valid_o  out  1  adder valid_i.
- dut_a_o, dut_b_o  out  32  adder A and B operands.
- dut_result_i  in  32  adder result_o.
- dut_done_i  in  1  adder done_o.
- dut_overflow_i, dut_underflow_i, dut_invalid_i  in  1  adder exception flags.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished (sticky until next start or reset).
- pass_o  out  1  valid while done_o=1; high only if err_count_o=0 and timeout_o=0.
- err_count_o  out  16  mismatches; saturates at 0xFFFF.
- tx_count_o  out  16  results checked; saturates at 0xFFFF.
- first_err_idx_o  out  ADDR_W  transaction index of the first mismatch (0 if none).
- timeout_o  out  1  drain phase timed out.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; FIFO is emptied; counters are cleared. Reset mid-run aborts immediately and does not resume.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start_i moves to RUN; rom_addr_o is set to 0 and all counters are cleared.
  - RUN: moves to DRAIN after address NUM_VECTORS-1 has been fetched.
  - DRAIN: moves to DONE when the FIFO is empty and no fetch is in flight, or on timeout.
  - DONE: start_i restarts as from IDLE.
  - start_i is ignored in RUN and DRAIN.
- Fetch/issue pipeline:
  - In RUN, rom_addr_o advances by 1 in each cycle where fifo_count + inflight < FIFO_DEPTH; otherwise it stalls.
  - A fetched word is always issued in the following cycle: dut_valid_o=1 for one cycle with A and B registered, and {Res, Flags} pushed into the FIFO in that same cycle.
  - dut_valid_o=0 whenever nothing is issued.
  - With the adder accepting every cycle, the steady-state rate is 1 vector per clock.
- Check: on dut_done_i=1, pop the FIFO head and increment tx_count.
  - Push and pop in the same cycle are legal; fifo_count is unchanged.
  - dut_done_i with an empty FIFO (and no same-cycle push): err_count++, no pop.
- Result match (first rule that applies decides):
  - (a) FTZ: dut_underflow_i=1 and result[30:0]=0 and golden[30:23]=0 -> match.
  - (b) Golden is NaN (exponent 255, mantissa != 0): match if and only if the result is any NaN.
  - (c) Bitwise equal -> match.
  - (d) |int(result) - int(golden)| <= ULP_TOL -> match.
- Flag match (golden flag bits: 0 inexact, 1 underflow, 2 overflow, 4 invalid):
  - overflow and invalid must be equal to golden.
  - underflow must be equal to golden, unless dut_underflow_i=1 and result[30:0]=0.
- Result or flag mismatch: err_count++. On the first mismatch only, first_err_idx_o <= tx index, 0-based.
- DRAIN timeout: an idle counter is cleared on every dut_done_i and increments otherwise. Reaching MAX_LATENCY sets timeout_o=1 and moves to DONE; entries still in the FIFO are not counted as errors.
- busy_o=1 in RUN and DRAIN. done_o and pass_o update in the cycle the FSM enters DONE.

Optional Feature:
- FP32_BIST_CAPTURE_EN defined: adds outputs first_err_got_o[31:0], first_err_exp_o[31:0] and first_err_flags_o[3:0] {inv, un, ov, mismatch_was_flag}. These latch on the first mismatch and clear on start or reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Ideal adder model (latency 3, golden results), NUM_VECTORS=100, start_i pulse -> 100 back-to-back dut_valid_o pulses; done_o=1, pass_o=1, tx_count_o=100, err_count_o=0.
- Vector 5 golden 0x3F800000, model returns 0x3F800003 -> no error; model returns 0x3F800004 -> err_count_o=1, first_err_idx_o=5.
- Golden 0x00000001 (denormal), model returns 0x80000000 with underflow=1 and golden flags underflow=0 -> match. Golden 0x7FC00000, model returns 0x7F800001 -> match.
- Model latency 40 with FIFO_DEPTH=16 -> issue stalls with never more than 16 outstanding, no FIFO overflow, pass_o=1.
- Model drops the last 2 results -> 64 cycles after the last done, timeout_o=1, done_o=1, pass_o=0. Spurious dut_done_i while idle before start -> ignored (FSM in IDLE).
- Assert rst_i mid-RUN at vector 37 -> all outputs 0 in the same cycle. A following start reruns from address 0 with counters starting from 0.
